alu_operand_sequencer: RTL and testbench

ALU_OPERAND_SEQUENCER -- requirements
Module: alu_operand_sequencer

---
 rtl/alu_operand_sequencer.sv | 167 ++++++++++++++++
 tb/tb_alu_operand_sequencer.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_operand_sequencer.sv
// -----------------------------------------------------------------------------
// alu_operand_sequencer
//
// Purpose: collects two operands and an operation from front-panel style
// controls, presents them in registers to an external combinational ALU,
// captures the ALU response one cycle later and shows it on a display bus.
// Sequence: S_A (operand A) -> S_B (operand B) -> S_OP (operation) ->
// S_EVAL (one-cycle capture) -> S_RES (result shown).
//
// Build option: define ALU_SEQ_CHAIN_EN to let enter in S_RES reuse a valid
// result as the next operand A (continue straight to S_B). Undefined, enter
// in S_RES restarts at S_A while the last result stays visible.
//
// Ports:
//   clk                 sole clock, rising edge
//   reset               asynchronous, active-high
//   entrada [n]         operand value from switches
//   enter               one-cycle pulse, accepts an operand
//   op_button [4]       one-cycle pulse, one-hot op (0001 add, 0010 sub,
//                       0100 and, 1000 or)
//   clear               one-cycle pulse, aborts and empties the sequence
//   numeroA/numeroB [n] registered operands to the ALU
//   button [4]          registered op code to the ALU (0 until op accepted)
//   resultado [n], overflow, underflow, valid_result
//                       combinational ALU response
//   result_reg [n]      captured ALU result
//   flags_reg [3]       captured {overflow, underflow, valid_result}
//   display [n]         entrada in S_A/S_B, numeroB in S_OP/S_EVAL,
//                       result_reg in S_RES
//   estado [3]          current state (S_A=0 .. S_RES=4)
//   op_count [8]        completed evaluations, wraps 255 -> 0
// -----------------------------------------------------------------------------
module alu_operand_sequencer #(
  parameter int n = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [n-1:0] entrada,
  input  logic         enter,
  input  logic [3:0]   op_button,
  input  logic         clear,
  output logic [n-1:0] numeroA,
  output logic [n-1:0] numeroB,
  output logic [3:0]   button,
  input  logic [n-1:0] resultado,
  input  logic         overflow,
  input  logic         underflow,
  input  logic         valid_result,
  output logic [n-1:0] result_reg,
  output logic [2:0]   flags_reg,
  output logic [n-1:0] display,
  output logic [2:0]   estado,
  output logic [7:0]   op_count
);

  typedef enum logic [2:0] {
    S_A    = 3'd0,
    S_B    = 3'd1,
    S_OP   = 3'd2,
    S_EVAL = 3'd3,
    S_RES  = 3'd4
  } state_t;

  state_t state;

  // Exactly one bit set; zero and multi-hot presses are ignored.
  logic op_valid;
  assign op_valid = $onehot(op_button);

  // NOTE: every register below is written with <= so all of them update from
  // the same pre-edge values; a blocking = here would create ordering hazards.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_A;
      numeroA    <= '0;
      numeroB    <= '0;
      button     <= '0;
      result_reg <= '0;
      flags_reg  <= '0;
      op_count   <= '0;
    end else if (clear) begin
      // Clear has priority over enter/op_button in every state, including
      // S_EVAL where it also suppresses the capture and the count.
      state      <= S_A;
      numeroA    <= '0;
      numeroB    <= '0;
      button     <= '0;
      result_reg <= '0;
      flags_reg  <= '0;
    end else begin
      case (state)
        S_A: begin
          if (enter) begin
            numeroA <= entrada;
            state   <= S_B;
          end
        end

        S_B: begin
          if (enter) begin
            numeroB <= entrada;
            state   <= S_OP;
          end
        end

        S_OP: begin
          // enter is deliberately not looked at here, so a coincident enter
          // is dropped while the op is accepted.
          if (op_valid) begin
            button <= op_button;
            state  <= S_EVAL;
          end
        end

        S_EVAL: begin
          // Operands and op have been stable since the previous edge, so the
          // ALU response is settled now.
          result_reg <= resultado;
          flags_reg  <= {overflow, underflow, valid_result};
          op_count   <= op_count + 8'd1;
          state      <= S_RES;
        end

        S_RES: begin
          if (enter) begin
`ifdef ALU_SEQ_CHAIN_EN
            if (flags_reg[0]) begin
              // Valid result becomes operand A; collect a fresh operand B.
              numeroA <= result_reg;
              numeroB <= '0;
              button  <= '0;
              state   <= S_B;
            end else begin
              numeroA <= '0;
              numeroB <= '0;
              button  <= '0;
              state   <= S_A;
            end
`else
            // result_reg is kept so the last answer stays visible.
            numeroA <= '0;
            numeroB <= '0;
            button  <= '0;
            state   <= S_A;
`endif
          end
        end

        default: state <= S_A;
      endcase
    end
  end

  assign estado = state;

  // NOTE: display is combinational, so it gets a default before the case to
  // keep every path assigned and avoid an inferred latch.
  always_comb begin
    display = entrada;
    case (state)
      S_OP, S_EVAL: display = numeroB;
      S_RES:        display = result_reg;
      default:      display = entrada;
    endcase
  end

endmodule

// File: tb/tb_alu_operand_sequencer.sv
// -----------------------------------------------------------------------------
// tb_alu_operand_sequencer
//
// Drives alu_operand_sequencer through directed scenarios and a randomized
// run of complete transactions. The external ALU is modelled in the bench;
// expected results come from plain arithmetic on the operands the bench chose.
// Works with or without ALU_SEQ_CHAIN_EN defined.
// -----------------------------------------------------------------------------
module tb_alu_operand_sequencer;

  localparam int N = 8;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic [N-1:0] entrada = '0;
  logic         enter = 1'b0;
  logic [3:0]   op_button = '0;
  logic         clear = 1'b0;
  logic [N-1:0] numeroA, numeroB, result_reg, display, resultado;
  logic [3:0]   button;
  logic         overflow, underflow, valid_result;
  logic [2:0]   flags_reg, estado;
  logic [7:0]   op_count;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_count = 0;

  alu_operand_sequencer #(.n(N)) dut (
    .clk          (clk),
    .reset        (reset),
    .entrada      (entrada),
    .enter        (enter),
    .op_button    (op_button),
    .clear        (clear),
    .numeroA      (numeroA),
    .numeroB      (numeroB),
    .button       (button),
    .resultado    (resultado),
    .overflow     (overflow),
    .underflow    (underflow),
    .valid_result (valid_result),
    .result_reg   (result_reg),
    .flags_reg    (flags_reg),
    .display      (display),
    .estado       (estado),
    .op_count     (op_count)
  );

  always #5 clk = ~clk;

  // Expected ALU behaviour: {result, overflow, underflow, valid}.
  function automatic logic [N+2:0] alu_ref(input int a, input int b, input logic [3:0] op);
    int r;
    logic ov, un, va;
    r = 0; ov = 0; un = 0; va = 0;
    case (op)
      4'b0001: begin r = a + b; ov = (r > 255); va = !ov; end
      4'b0010: begin r = a - b; un = (a < b);   va = !un; end
      4'b0100: begin r = a & b; va = 1; end
      4'b1000: begin r = a | b; va = 1; end
      default: begin r = 0; end
    endcase
    return {r[N-1:0], ov, un, va};
  endfunction

  // External combinational ALU seen by the DUT.
  always_comb begin
    {resultado, overflow, underflow, valid_result} =
      alu_ref(int'(numeroA), int'(numeroB), button);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 ns after it.
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_enter(input logic [N-1:0] v);
    entrada = v; enter = 1'b1;
    tick();
    enter = 1'b0;
  endtask

  task automatic do_op(input logic [3:0] op);
    op_button = op;
    tick();
    op_button = 4'b0000;
  endtask

  task automatic do_clear;
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  // Full evaluation from S_A; checks result, flags, count against the model.
  task automatic run_txn(input string tag, input logic [N-1:0] a, input logic [N-1:0] b,
                         input logic [3:0] op);
    logic [N+2:0] e;
    e = alu_ref(int'(a), int'(b), op);
    do_enter(a);
    do_enter(b);
    do_op(op);
    tick();
    exp_count++;
    check({tag, "_result"}, 32'(result_reg), 32'(e[N+2:3]));
    check({tag, "_flags"},  32'(flags_reg),  32'(e[2:0]));
    check({tag, "_count"},  32'(op_count),   32'(exp_count % 256));
  endtask

  initial begin
    logic [N-1:0] ra, rb;
    logic [3:0]   rop, bad;

    // ---------------- asynchronous reset, no clock edge needed ----------
    #1 reset = 1'b1;
    #1;
    check("rst_estado",  32'(estado),     0);
    check("rst_numeroA", 32'(numeroA),    0);
    check("rst_numeroB", 32'(numeroB),    0);
    check("rst_button",  32'(button),     0);
    check("rst_result",  32'(result_reg), 0);
    check("rst_flags",   32'(flags_reg),  0);
    check("rst_count",   32'(op_count),   0);
    tick();
    reset = 1'b0;
    tick();

    // ---------------- 200 + 100 ------------------------------------------
    entrada = 8'd33;
    #1 check("sa_display", 32'(display), 33);
    do_enter(8'd200);
    check("a_estado",  32'(estado),  1);
    check("a_numeroA", 32'(numeroA), 200);
    do_enter(8'd100);
    check("b_estado",  32'(estado),  2);
    check("b_numeroB", 32'(numeroB), 100);
    check("b_button",  32'(button),  0);
    check("sop_display", 32'(display), 100);
    do_enter(8'd7);    // enter in S_OP is ignored
    check("sop_enter_estado",  32'(estado),  2);
    check("sop_enter_numeroB", 32'(numeroB), 100);
    do_op(4'b0001);
    check("eval_estado", 32'(estado), 3);
    check("eval_button", 32'(button), 1);
    check("eval_result_not_yet", 32'(result_reg), 0);
    tick();
    exp_count++;
    check("add_estado",  32'(estado),     4);
    check("add_result",  32'(result_reg), 44);
    check("add_flags",   32'(flags_reg),  3'b100);
    check("add_count",   32'(op_count),   1);
    check("add_button",  32'(button),     1);
    check("res_display", 32'(display),    44);
    tick();            // S_RES holds without enter
    check("res_hold", 32'(result_reg), 44);
    do_enter(8'd0);    // invalid result: restart at S_A in both builds
    check("res_enter_estado",  32'(estado),     0);
    check("res_enter_numeroA", 32'(numeroA),    0);
    check("res_enter_keep",    32'(result_reg), 44);

    // ---------------- 5 - 9 ---------------------------------------------
    run_txn("sub", 8'd5, 8'd9, 4'b0010);
    check("sub_result_const", 32'(result_reg), 252);
    check("sub_flags_const",  32'(flags_reg),  3'b010);
    do_enter(8'd0);
    check("sub_back_estado", 32'(estado), 0);

    // ---------------- F0 & 3C, with ignored multi-hot/zero op -------------
    do_enter(8'hF0);
    do_enter(8'h3C);
    do_op(4'b0011);
    check("multihot_estado", 32'(estado), 2);
    check("multihot_button", 32'(button), 0);
    do_op(4'b0000);
    check("zero_op_estado", 32'(estado), 2);
    do_op(4'b0100);
    tick();
    exp_count++;
    check("and_result", 32'(result_reg), 8'h30);
    check("and_flags",  32'(flags_reg),  3'b001);
    check("and_count",  32'(op_count),   exp_count);

    // ---------------- clear in S_RES -------------------------------------
    do_clear();
    check("clr_res_estado", 32'(estado),     0);
    check("clr_res_result", 32'(result_reg), 0);
    check("clr_res_flags",  32'(flags_reg),  0);
    check("clr_res_count",  32'(op_count),   exp_count);

    // ---------------- chaining / restart ---------------------------------
    run_txn("chain_add", 8'd10, 8'd20, 4'b0001);
    do_enter(8'd99);
`ifdef ALU_SEQ_CHAIN_EN
    check("chain_estado",  32'(estado),  1);
    check("chain_numeroA", 32'(numeroA), 30);
    check("chain_numeroB", 32'(numeroB), 0);
    check("chain_button",  32'(button),  0);
    do_enter(8'd5);
    do_op(4'b0010);
    tick();
    exp_count++;
    check("chain_result", 32'(result_reg), 25);
    check("chain_flags",  32'(flags_reg),  3'b001);
    do_clear();
`else
    check("nochain_estado",  32'(estado),     0);
    check("nochain_numeroA", 32'(numeroA),    0);
    check("nochain_button",  32'(button),     0);
    check("nochain_keep",    32'(result_reg), 30);
`endif

    // ---------------- clear coincident with enter, clear in S_B -----------
    entrada = 8'd55; enter = 1'b1; clear = 1'b1;
    tick();
    enter = 1'b0; clear = 1'b0;
    check("clr_enter_estado",  32'(estado),  0);
    check("clr_enter_numeroA", 32'(numeroA), 0);
    do_enter(8'd77);
    check("sb_numeroA", 32'(numeroA), 77);
    do_clear();
    check("clr_sb_estado",  32'(estado),   0);
    check("clr_sb_numeroA", 32'(numeroA),  0);
    check("clr_sb_count",   32'(op_count), exp_count);

    // ---------------- clear in S_EVAL suppresses capture ------------------
    do_enter(8'd1);
    do_enter(8'd2);
    do_op(4'b1000);
    check("pre_clr_eval_estado", 32'(estado), 3);
    do_clear();
    check("clr_eval_estado", 32'(estado),     0);
    check("clr_eval_count",  32'(op_count),   exp_count);
    check("clr_eval_result", 32'(result_reg), 0);
    check("clr_eval_button", 32'(button),     0);

    // ---------------- reset pulse mid S_EVAL, asynchronous ----------------
    do_enter(8'd3);
    do_enter(8'd4);
    do_op(4'b0001);
    reset = 1'b1;
    #1;
    check("rst_eval_estado",  32'(estado),   0);
    check("rst_eval_numeroA", 32'(numeroA),  0);
    check("rst_eval_button",  32'(button),   0);
    check("rst_eval_count",   32'(op_count), 0);
    #1 reset = 1'b0;
    exp_count = 0;
    do_enter(8'd66);   // first enter after reset is taken
    check("post_rst_estado",  32'(estado),  1);
    check("post_rst_numeroA", 32'(numeroA), 66);
    do_clear();

    // ---------------- randomized transactions, 256 -> count wraps ---------
    for (int i = 0; i < 256; i++) begin
      ra  = 8'($urandom);
      rb  = 8'($urandom);
      rop = 4'b0001 << $urandom_range(0, 3);
      do_enter(ra);
      do_enter(rb);
      if ($urandom_range(0, 3) == 0) begin
        do bad = 4'($urandom_range(0, 15));
        while (bad == 4'd1 || bad == 4'd2 || bad == 4'd4 || bad == 4'd8);
        do_op(bad);
        check("rnd_bad_op_estado", 32'(estado), 2);
      end
      enter = ($urandom_range(0, 1) == 1);   // coincident enter is dropped
      do_op(rop);
      enter = 1'b0;
      check("rnd_eval_estado", 32'(estado),  3);
      check("rnd_eval_button", 32'(button),  32'(rop));
      check("rnd_eval_numeroB", 32'(numeroB), 32'(rb));
      tick();
      begin
        logic [N+2:0] e;
        e = alu_ref(int'(ra), int'(rb), rop);
        exp_count++;
        check("rnd_result", 32'(result_reg), 32'(e[N+2:3]));
        check("rnd_flags",  32'(flags_reg),  32'(e[2:0]));
        check("rnd_count",  32'(op_count),   32'(exp_count % 256));
      end
      do_clear();
    end
    check("op_count_wrap", 32'(op_count), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Safety net so the run always ends.
  initial begin
    #500000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
